// File: rtl/sd_arb_pkg.sv
// Shared types and sizing helpers for the SD request arbiter.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_XFER,
    ARB_RELEASE
  } arb_state_t;

  // Wide enough for the default 2**20-cycle host response window.
  localparam int TIMER_W = 21;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_req_arbiter_if.sv
// Requester-side and host-side signals of the SD request arbiter.
interface sd_req_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int LBA_W   = 32
) ();
  import sd_arb_pkg::*;

  localparam int GW = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0][LBA_W-1:0] req_lba;
  logic [NUM_REQ-1:0]            req_rd;
  logic [NUM_REQ-1:0]            req_wr;
  logic [NUM_REQ-1:0]            req_ack;
  logic [NUM_REQ-1:0][7:0]       req_buff_din;
  logic [8:0]                    req_buff_addr;
  logic [7:0]                    req_buff_dout;
  logic                          req_buff_wr;
  logic [LBA_W-1:0]              sd_lba;
  logic                          sd_rd;
  logic                          sd_wr;
  logic                          sd_ack;
  logic [8:0]                    sd_buff_addr;
  logic [7:0]                    sd_buff_dout;
  logic [7:0]                    sd_buff_din;
  logic                          sd_buff_wr;
  logic [GW-1:0]                 grant;
  logic                          busy;
  logic                          timeout_err;

  // The arbiter side.
  modport slave (
    input  req_lba, req_rd, req_wr, req_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    output req_ack, req_buff_addr, req_buff_dout, req_buff_wr,
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    output grant, busy, timeout_err
  );

  // The environment: requesters plus the host block port.
  modport master (
    output req_lba, req_rd, req_wr, req_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    input  req_ack, req_buff_addr, req_buff_dout, req_buff_wr,
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  grant, busy, timeout_err
  );

endinterface

// File: rtl/sd_arb_rr_pick.sv
// Combinational round-robin picker: first candidate strictly after last, wrapping.
module sd_arb_rr_pick #(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  cand,
  input  logic [GW-1:0] last,
  output logic          valid,
  output logic [GW-1:0] idx
);

  logic          hi_valid;
  logic [GW-1:0] hi_idx;
  logic [GW-1:0] lo_idx;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hi_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        lo_idx = GW'(i);
        if (i > int'(last)) begin
          hi_valid = 1'b1;
          hi_idx   = GW'(i);
        end
      end
    end
  end

  assign valid = |cand;
  assign idx   = hi_valid ? hi_idx : lo_idx;

endmodule

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter multiplexing several sector requesters onto one HPS block port.
module sd_req_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LBA_W   = 32,
  parameter int TIMEOUT = 2**20
) (
  input  logic            clock,
  input  logic            RESET_N,
  sd_req_arbiter_if.slave bus
);

  localparam int                 GW         = idx_w(NUM_REQ);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  arb_state_t         state_reg;
  arb_state_t         state_next;
  logic [GW-1:0]      grant_reg;
  logic [GW-1:0]      last_grant_reg;
  logic [NUM_REQ-1:0] mask_reg;
  logic [NUM_REQ-1:0] mask_next;
  logic [TIMER_W-1:0] timer_reg;
  logic [LBA_W-1:0]   sd_lba_reg;
  logic               sd_rd_reg;
  logic               sd_wr_reg;
  logic               timeout_err_reg;

  logic [NUM_REQ-1:0] active;
  logic [NUM_REQ-1:0] cand;
  logic               pick_valid;
  logic [GW-1:0]      pick_idx;
  logic               timeout_hit;
  logic               busy;
  logic               in_grant;

  assign active = bus.req_rd | bus.req_wr;
  assign cand   = active & ~mask_reg;

  sd_arb_rr_pick #(
    .N  (NUM_REQ),
    .GW (GW)
  ) u_pick (
    .cand  (cand),
    .last  (last_grant_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // An ack on the terminal-count cycle wins over the timeout.
  assign timeout_hit = (state_reg == ARB_ISSUE) && !bus.sd_ack && (timer_reg == TIMER_LAST);

  always_ff @(posedge clock or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= ARB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE:    if (pick_valid) state_next = ARB_ISSUE;
      ARB_ISSUE: begin
        if (bus.sd_ack)       state_next = ARB_XFER;
        else if (timeout_hit) state_next = ARB_RELEASE;
      end
      ARB_XFER:    if (!bus.sd_ack) state_next = ARB_RELEASE;
      ARB_RELEASE: state_next = ARB_IDLE;
      default:     state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_reg != ARB_IDLE);
    in_grant = (state_reg == ARB_ISSUE) || (state_reg == ARB_XFER);
  end

  // A masked requester stays blocked until it withdraws its request.
  always_comb begin
    mask_next = mask_reg & active;
    if (timeout_hit) mask_next[grant_reg] = 1'b1;
  end

  always_ff @(posedge clock or negedge RESET_N) begin
    if (!RESET_N) begin
      grant_reg       <= '0;
      last_grant_reg  <= GW'(NUM_REQ - 1);
      mask_reg        <= '0;
      timer_reg       <= '0;
      sd_lba_reg      <= '0;
      sd_rd_reg       <= 1'b0;
      sd_wr_reg       <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      timeout_err_reg <= timeout_hit;
      mask_reg        <= mask_next;
      case (state_reg)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant_reg  <= pick_idx;
            sd_lba_reg <= bus.req_lba[pick_idx];
            sd_rd_reg  <= bus.req_rd[pick_idx];
            sd_wr_reg  <= ~bus.req_rd[pick_idx];
            timer_reg  <= '0;
          end
        end
        ARB_ISSUE: begin
          timer_reg <= timer_reg + TIMER_W'(1);
          if (bus.sd_ack || timeout_hit) begin
            sd_rd_reg <= 1'b0;
            sd_wr_reg <= 1'b0;
          end
        end
        ARB_RELEASE: last_grant_reg <= grant_reg;
        default: ;
      endcase
    end
  end

  // Ack and buffer-write paths stay combinational so requesters can qualify writes in-cycle.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
      assign bus.req_ack[gi] = bus.sd_ack & in_grant & (grant_reg == GW'(gi));
    end
  endgenerate

  assign bus.req_buff_wr   = bus.sd_buff_wr & in_grant;
  assign bus.req_buff_addr = bus.sd_buff_addr;
  assign bus.req_buff_dout = bus.sd_buff_dout;
  assign bus.sd_buff_din   = bus.req_buff_din[grant_reg];
  assign bus.sd_lba        = sd_lba_reg;
  assign bus.sd_rd         = sd_rd_reg;
  assign bus.sd_wr         = sd_wr_reg;
  assign bus.grant         = grant_reg;
  assign bus.busy          = busy;
  assign bus.timeout_err   = timeout_err_reg;

endmodule
